mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle signed multiply/divide responder serving the CPU control unit (`unid_controle`). Operand sources come from the MDSrcA/MDSrcB muxes, and results are returned for the HI and LO registers. The control unit acts as initiator: it pulses `start` with an operation, waits on `busy`/`done`, then loads HI/LO. Division by zero is reported on a flag so the control unit can take the Div0 exception path (vector 0xFF).

## Interface
Parameters:
- WIDTH, 32, operand/result width.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  request strobe; sampled only in IDLE.
- op_div  in  1  0 = signed mult, 1 = signed div.
- src_a  in  WIDTH  multiplicand / dividend (from MDSrcA).
- src_b  in  WIDTH  multiplier / divisor (from MDSrcB).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi_out/lo_out valid.
- div_zero  out  1  one-cycle pulse, coincident with done, on div with src_b = 0.
- hi_out  out  WIDTH  mult: product[63:32]; div: remainder.
- lo_out  out  WIDTH  mult: product[31:0]; div: quotient.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch op_div, signs of src_a/src_b, |src_a|, |src_b|; clear the 64-bit accumulator and counter.
  - If op_div=1 and src_b=0, go to FIX with a zero flag set. Otherwise go to RUN.
- RUN: one iteration per cycle; the counter runs 0..ITER-1. After iteration ITER-1, go to FIX.
  - Mult: unsigned shift-add on the magnitudes; 64-bit partial product.
  - Div: restoring division on the magnitudes; one quotient bit per cycle.
- FIX: sign correction, result registers written, then return to IDLE.
  - Mult: negate the 64-bit product if sign_a XOR sign_b.
  - Div: negate the quotient if sign_a XOR sign_b; negate the remainder if sign_a=1, so the remainder takes the dividend's sign (truncating division).
  - Zero flag set: hi_out/lo_out keep their previous values; div_zero=1 and done=1.
- Width rules:
  - |0x80000000| = 0x80000000 is treated as unsigned.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no flag).
- start while busy=1 is ignored, with no queuing. start in the same cycle as done is ignored; the unit accepts a new start on the next cycle.
- Operands are latched; changes on src_a/src_b after acceptance have no effect.
- Reset (any time, including mid-operation): state=IDLE; busy, done, div_zero = 0; hi_out, lo_out = 0; the accumulator is cleared.

## Timing
- Let E0 be the rising edge at which start is sampled in IDLE.
- Normal op: RUN covers edges E1..E32; FIX is entered after E32.
  - At E33: hi_out/lo_out are registered and done=1 for the cycle E33–E34.
  - busy=1 from E0 through E33; busy=0 in the done cycle.
- Div by zero: FIX is entered after E0. At E1, done=1 and div_zero=1 for one cycle; busy=1 for E0..E1 only.
- All outputs are registered; there is no combinational path from start/src to any output.

## Structure
- Shared package `cpu_pkg`: state encoding (IDLE/RUN/FIX), op encoding (OP_MULT=0, OP_DIV=1), MD_ITER=32 constant.
- Single module; no sub-module required.
- The accumulator datapath is one always block: 64-bit register, plus a 33-bit subtractor for division.

## Test plan
- mult: src_a=7, src_b=0xFFFFFFFD (−3) -> at E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse, div_zero=0.
- mult: 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
- div: src_a=0xFFFFFFF9 (−7), src_b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Also 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- div by zero: preload hi=0x12345678 via a prior op; div 5/0 -> at E1, done=1 and div_zero=1, hi/lo unchanged, busy low at E2.
- start pulsed at E5 during a run with different operands -> ignored; the result matches the first operation, and done fires once at E33.
- reset driven low at E10 of a mult -> busy, done, hi, lo = 0 immediately (async). After release, a new start runs a full 33-cycle operation correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state/op encodings and iteration count for the multiply/divide unit.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mdState_t;
  typedef enum logic {OP_MULT = 1'b0, OP_DIV = 1'b1} mdOp_t;
  localparam int MD_ITER = 32;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/response bundle between the control unit and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  modport master (output start, op_div, src_a, src_b, input busy, done, div_zero, hi_out, lo_out);
  modport slave (input start, op_div, src_a, src_b, output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (shift-add) and divide (restoring) on operand magnitudes,
// sign-corrected in a final cycle into HI/LO.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MD_ITER
) (
  input logic clock,
  input logic reset,
  mult_div_unit_if.slave md
);
  localparam int CW = $clog2(ITER);
  mdState_t state, stateNext;
  mdOp_t opReg;
  logic signA, signB, zeroFlag, accept, lastIter, divGe;
  logic [WIDTH-1:0] magA, magB, quotFix, remFix;
  logic [2*WIDTH-1:0] acc, prodFix;
  logic [WIDTH:0] mulSum, divCand, divDiff;
  logic [CW-1:0] cnt;
  // A start coinciding with done is dropped so the control unit sees one clean handoff.
  assign accept   = state == IDLE && md.start && !md.done;
  assign lastIter = cnt == CW'(ITER - 1);
  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, magA & {WIDTH{magB[0]}}};
  assign divCand  = {acc[2*WIDTH-1:WIDTH], magA[WIDTH-1]};
  assign divDiff  = divCand - {1'b0, magB};
  assign divGe    = divCand >= {1'b0, magB};
  assign prodFix  = (signA ^ signB) ? -acc : acc;
  assign quotFix  = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFix   = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    if (accept) stateNext = (md.op_div && md.src_b == '0) ? FIX : RUN;
    else if (state == RUN) stateNext = lastIter ? FIX : RUN;
    else if (state == FIX) stateNext = IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opReg       <= OP_MULT;
      signA       <= 1'b0;
      signB       <= 1'b0;
      zeroFlag    <= 1'b0;
      magA        <= '0;
      magB        <= '0;
      acc         <= '0;
      cnt         <= '0;
      md.busy     <= 1'b0;
      md.done     <= 1'b0;
      md.div_zero <= 1'b0;
      md.hi_out   <= '0;
      md.lo_out   <= '0;
    end else begin
      md.done     <= 1'b0;
      md.div_zero <= 1'b0;
      if (accept) begin
        opReg    <= mdOp_t'(md.op_div);
        signA    <= md.src_a[WIDTH-1];
        signB    <= md.src_b[WIDTH-1];
        magA     <= md.src_a[WIDTH-1] ? -md.src_a : md.src_a;
        magB     <= md.src_b[WIDTH-1] ? -md.src_b : md.src_b;
        zeroFlag <= md.op_div && md.src_b == '0;
        acc      <= '0;
        cnt      <= '0;
        md.busy  <= 1'b1;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        // Divide shifts dividend bits out of magA; multiply consumes multiplier bits from magB.
        if (opReg == OP_DIV) begin
          acc  <= {divGe ? divDiff[WIDTH-1:0] : divCand[WIDTH-1:0], acc[WIDTH-2:0], divGe};
          magA <= magA << 1;
        end else begin
          acc  <= {mulSum, acc[WIDTH-1:1]};
          magB <= magB >> 1;
        end
      end else if (state == FIX) begin
        md.busy     <= 1'b0;
        md.done     <= 1'b1;
        md.div_zero <= zeroFlag;
        if (!zeroFlag) begin
          md.hi_out <= opReg == OP_DIV ? remFix : prodFix[2*WIDTH-1:WIDTH];
          md.lo_out <= opReg == OP_DIV ? quotFix : prodFix[WIDTH-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a result scoreboard popped by a done-triggered monitor.
module tb_mult_div_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int failed = 0;
  exp_t sb[$];
  mult_div_unit_if #(.WIDTH(32)) md ();
  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (.clock(clock), .reset(reset), .md(md));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (reset && md.done === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected no done", md.hi_out, md.lo_out);
      end else begin
        e = sb.pop_front();
        chk("hi_out", md.hi_out, e.hi);
        chk("lo_out", md.lo_out, e.lo);
        chk("div_zero", {31'b0, md.div_zero}, {31'b0, e.z});
      end
    end
  end
  task automatic doOp(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input logic ez,
                      input int extraAt = 0, input int rstAt = 0, input bit holdDone = 0);
    int k = 0;
    bit got = 0;
    int lat = ez ? 1 : 33;
    exp_t e;
    @(negedge clock);
    md.start = 1'b1;
    md.op_div = op;
    md.src_a = a;
    md.src_b = b;
    e.hi = eh;
    e.lo = el;
    e.z = ez;
    if (rstAt == 0) sb.push_back(e);
    @(posedge clock);
    #1;
    md.start = 1'b0;
    md.src_a = ~a;
    md.src_b = ~b;
    chk("busy_after_accept", {31'b0, md.busy}, 32'd1);
    while (k < 40 && !got) begin
      @(posedge clock);
      #1;
      k++;
      if (k == extraAt - 1) begin
        md.start = 1'b1;
        md.op_div = ~op;
        md.src_a = 32'd3;
        md.src_b = 32'd3;
      end
      if (k == extraAt) md.start = 1'b0;
      if (k == 16) chk("busy_mid_run", {31'b0, md.busy}, 32'd1);
      if (k == rstAt) begin
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'b0, md.busy}, 32'd0);
        chk("rst_done", {31'b0, md.done}, 32'd0);
        chk("rst_hi", md.hi_out, 32'd0);
        chk("rst_lo", md.lo_out, 32'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        return;
      end
      if (md.done === 1'b1) got = 1;
    end
    chk("latency", k, lat);
    chk("busy_in_done", {31'b0, md.busy}, 32'd0);
    if (holdDone) begin
      md.start = 1'b1;
      md.op_div = 1'b0;
      md.src_a = 32'd5;
      md.src_b = 32'd5;
    end
    @(posedge clock);
    #1;
    md.start = 1'b0;
    chk("busy_after_done", {31'b0, md.busy}, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    md.start = 1'b0;
    md.op_div = 1'b0;
    md.src_a = '0;
    md.src_b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", {31'b0, md.busy}, 32'd0);
    chk("reset_done", {31'b0, md.done}, 32'd0);
    chk("reset_div_zero", {31'b0, md.div_zero}, 32'd0);
    chk("reset_hi", md.hi_out, 32'd0);
    chk("reset_lo", md.lo_out, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    doOp(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 0, 1);
    doOp(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    doOp(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    doOp(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    doOp(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    doOp(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    doOp(1'b1, 32'h32345678, 32'h20000000, 32'h12345678, 32'd1, 1'b0);
    doOp(1'b1, 32'd5, 32'd0, 32'h12345678, 32'd1, 1'b1);
    doOp(1'b0, 32'hFFFFFF9C, 32'd200, 32'hFFFFFFFF, 32'hFFFFB1E0, 1'b0, 5);
    doOp(1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 32'hFFFE0001, 1'b0, 0, 10);
    doOp(1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 32'hFFFE0001, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
